// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] R15_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues single-outstanding IMEM requests and
// buffers returned instructions for Decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus8_d
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     FULL_LEVEL = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          drop;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          resp;
    logic          push;
    logic          pop;
    logic          issue;

    // A stray imem_valid with nothing in flight is ignored.
    assign resp      = imem_valid && outstanding;
    assign push      = resp && !drop && !redirect;
    assign push_data = '{instr: imem_rdata, pc: req_pc};

    // The in-flight request already owns a slot; a same-cycle pop is not credited.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign issue     = reset && !redirect && (!outstanding || imem_valid)
                       && (occupancy < FULL_LEVEL);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign valid_d   = (count != '0) && !redirect;
    assign pop       = valid_d && !stall_d;
    assign instr_d   = head.instr;
    assign pc_d      = head.pc;
    assign pcplus8_d = head.pc + R15_OFFSET;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= PC_RESET;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (redirect)   fetch_pc <= redirect_pc;
            else if (issue) fetch_pc <= fetch_pc + PC_STEP;

            if (issue) req_pc <= fetch_pc;

            if (issue)     outstanding <= 1'b1;
            else if (resp) outstanding <= 1'b0;

            // A request still in flight at redirect returns stale data.
            if (redirect)  drop <= outstanding && !imem_valid;
            else if (resp) drop <= 1'b0;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (redirect),
        .count     (count),
        .head      (head)
    );

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
        imem_valid |-> outstanding);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, corner sequences and random traffic
// against a queue-based reference model with a variable-latency IMEM.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus8_d;

    fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .stall_d     (stall_d),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pcplus8_d   (pcplus8_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // IMEM responder
    bit          r_pend = 0;
    int          r_rem  = 0;
    logic [31:0] r_addr = '0;
    int          lat    = 1;
    logic [31:0] dxor   = '0;

    // Reference model
    fetch_entry_t m_q[$];
    logic [31:0]  m_fpc  = '0;
    logic [31:0]  m_addr = '0;
    bit           m_out  = 0;
    bit           m_drop = 0;
    bit           e_valid;
    bit           e_req;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s @%0t: event did not occur within cycle budget", name, $time);
    endtask

    task automatic drive(input logic r, input logic [31:0] rpc, input logic st);
        @(negedge clk);
        reset       = 1'b1;
        redirect    = r;
        redirect_pc = rpc;
        stall_d     = st;
        if (r_pend) r_rem--;
        imem_valid = r_pend && (r_rem == 0);
        imem_rdata = imem_valid ? (r_addr ^ dxor) : $urandom;
        #1;
        e_valid = (m_q.size() != 0) && !r;
        e_req   = !r && (!m_out || imem_valid) && (m_q.size() + int'(m_out) < DEPTH);
    endtask

    task automatic model_check();
        chk("valid_d", valid_d, e_valid);
        if (e_valid) begin
            chk("pc_d", pc_d, m_q[0].pc);
            chk("instr_d", instr_d, m_q[0].instr);
            chk("pcplus8_d", pcplus8_d, m_q[0].pc + 32'd8);
        end
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_fpc);
    endtask

    task automatic advance();
        bit resp;
        if (imem_valid) r_pend = 0;
        if (imem_req) begin
            r_pend = 1;
            r_rem  = lat;
            r_addr = imem_addr;
        end
        resp = imem_valid && m_out;
        if (e_valid && !stall_d) void'(m_q.pop_front());
        if (redirect) begin
            m_q.delete();
            m_drop = m_out && !resp;
            if (resp) m_out = 0;
            m_fpc = redirect_pc;
        end else begin
            if (resp) begin
                if (!m_drop) m_q.push_back('{instr: imem_rdata, pc: m_addr});
                m_out  = 0;
                m_drop = 0;
            end
            if (e_req) begin
                m_out  = 1;
                m_addr = m_fpc;
                m_fpc  = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] rpc, input logic st);
        drive(r, rpc, st);
        model_check();
        advance();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " imem_req"}, imem_req, 32'd0);
        chk({tag, " valid_d"}, valid_d, 32'd0);
        chk({tag, " instr_d"}, instr_d, 32'd0);
        chk({tag, " pc_d"}, pc_d, 32'd0);
        chk({tag, " pcplus8_d"}, pcplus8_d, 32'd8);
    endtask

    initial begin
        bit          found;
        logic [31:0] wrap_exp[3];
        int          nwrap;

        reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_valid = 1'b0; imem_rdata = '0; stall_d = 1'b0;

        // stall, req, addr, valid, pc  (1-cycle IMEM, data = addr)
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[7]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[14] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
        tbl[15] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h1C};
        tbl[16] = '{1'b0, 1'b1, 32'h2C, 1'b1, 32'h20};
        tbl[17] = '{1'b0, 1'b1, 32'h30, 1'b1, 32'h24};

        #12;
        check_reset_outputs("reset");

        lat = 1; dxor = '0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 32'h0, tbl[i].stall);
            chk($sformatf("tbl%0d imem_req", i), imem_req, tbl[i].req);
            if (tbl[i].req) chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d valid_d", i), valid_d, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d pc_d", i), pc_d, tbl[i].pc);
                chk($sformatf("tbl%0d instr_d", i), instr_d, tbl[i].pc);
                chk($sformatf("tbl%0d pcplus8_d", i), pcplus8_d, tbl[i].pc + 32'd8);
            end
            advance();
        end

        // 3-cycle IMEM latency
        lat = 3; dxor = 32'h5A5A_0000;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0);

        // Redirect while a request is in flight and not returning this cycle
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (r_pend && r_rem >= 2) found = 1;
            else step(1'b0, 32'h0, 1'b0);
        end
        if (!found) timeout("redir_setup");
        drive(1'b1, 32'h100, 1'b0);
        model_check();
        chk("redir valid_d", valid_d, 32'd0);
        chk("redir imem_req", imem_req, 32'd0);
        advance();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            model_check();
            if (imem_req) begin
                chk("redir next imem_addr", imem_addr, 32'h100);
                found = 1;
            end
            advance();
        end
        if (!found) timeout("redir issue");
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            model_check();
            if (valid_d) begin
                chk("redir first pc_d", pc_d, 32'h100);
                found = 1;
            end
            advance();
        end
        if (!found) timeout("redir valid");

        // Redirect coinciding with imem_valid while Decode stalls
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h200, 1'b1);
        model_check();
        chk("coinc valid_d", valid_d, 32'd0);
        advance();
        drive(1'b0, 32'h0, 1'b0);
        model_check();
        chk("coinc empty valid_d", valid_d, 32'd0);
        chk("coinc imem_req", imem_req, 32'd1);
        chk("coinc imem_addr", imem_addr, 32'h200);
        advance();

        // PC wrap
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        step(1'b1, 32'hFFFF_FFF8, 1'b0);
        nwrap = 0;
        for (int i = 0; i < 20 && nwrap < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            model_check();
            if (imem_req) begin
                chk($sformatf("wrap addr%0d", nwrap), imem_addr, wrap_exp[nwrap]);
                nwrap++;
            end
            advance();
        end
        if (nwrap < 3) timeout("wrap issue");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic        r;
            logic [31:0] rpc;
            lat  = $urandom_range(1, 4);
            dxor = $urandom;
            r    = ($urandom_range(0, 99) < 6);
            rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                 : ($urandom & 32'hFFFF_FFFC);
            step(r, rpc, ($urandom_range(0, 99) < 30));
        end

        // Asynchronous reset with a non-empty queue
        lat = 1;
        step(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0; imem_valid = 1'b0; redirect = 1'b0; stall_d = 1'b0;
        #1;
        check_reset_outputs("async reset");
        r_pend = 0;
        m_q.delete(); m_fpc = '0; m_out = 0; m_drop = 0;
        @(negedge clk);
        #1;
        check_reset_outputs("held reset");
        for (int i = 0; i < 30; i++) begin
            lat = $urandom_range(1, 3);
            step(1'b0, 32'h0, ($urandom_range(0, 99) < 25));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
